// File: rtl/neuron_argmax_pkg.sv
// Shared sizing and state encoding for the output-layer argmax stage.
// Score widths match the neuron layer so the packed score bus lines up.
package neuron_argmax_pkg;

    localparam int NUM_NEURONS  = 10;
    localparam int OUTPUT_WIDTH = 26;
    localparam int CLASS_WIDTH  = 4;

    localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/neuron_argmax.sv
// Serial argmax over the neuron scores: snapshot on start, one signed compare
// per cycle, registered winner index/value with a one-cycle done pulse.
module neuron_argmax
    import neuron_argmax_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] IN_SCORES,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [CLASS_WIDTH-1:0]              CLASS,
    output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE
);

    state_t state, next_state;
    logic [CLASS_WIDTH-1:0] cnt;
    logic load, step, finish;

    logic signed [OUTPUT_WIDTH-1:0] snap_p0 [NUM_NEURONS];
    logic signed [OUTPUT_WIDTH-1:0] best_val_p0;
    logic        [CLASS_WIDTH-1:0]  best_idx_p0;

    logic signed [OUTPUT_WIDTH-1:0] cand;
    logic                           gt;
    logic signed [OUTPUT_WIDTH-1:0] win_val;
    logic        [CLASS_WIDTH-1:0]  win_idx;

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SCAN;
                    load       = 1'b1;
                end
            end
            SCAN: begin
                step = 1'b1;
                if (cnt == LAST_IDX) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strict greater-than: an equal later score never displaces the current best,
    // so ties go to the lowest index.
    always_comb begin
        cand    = snap_p0[cnt];
        gt      = cand > best_val_p0;
        win_val = gt ? cand : best_val_p0;
        win_idx = gt ? cnt  : best_idx_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            CLASS     <= '0;
            MAX_SCORE <= '0;
        end else begin
            state <= next_state;
            done  <= finish;
            if (load) begin
                cnt <= CLASS_WIDTH'(1);
            end else if (step) begin
                cnt <= cnt + CLASS_WIDTH'(1);
            end
            if (finish) begin
                CLASS     <= win_idx;
                MAX_SCORE <= win_val;
            end
        end
    end

    // Snapshot and running best are pure datapath; the FSM guards their use.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                snap_p0[i] <= IN_SCORES[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            end
            best_val_p0 <= IN_SCORES[0 +: OUTPUT_WIDTH];
            best_idx_p0 <= '0;
        end else if (step) begin
            best_val_p0 <= win_val;
            best_idx_p0 <= win_idx;
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_neuron_argmax.sv
// Bench for neuron_argmax: directed corner cases plus randomized score sets
// checked against a plain first-maximum search over the applied scores.
module tb_neuron_argmax;
    import neuron_argmax_pkg::*;

    localparam int N = NUM_NEURONS;
    localparam int W = OUTPUT_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N*W-1:0]         IN_SCORES;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [CLASS_WIDTH-1:0] CLASS;
    logic [W-1:0]           MAX_SCORE;

    int checks = 0;
    int errors = 0;

    logic signed [W-1:0] sc [N];

    neuron_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .IN_SCORES (IN_SCORES),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .CLASS     (CLASS),
        .MAX_SCORE (MAX_SCORE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_scores();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = sc[i];
        return v;
    endfunction

    // Reference: index of the first occurrence of the maximum signed value.
    task automatic model(output int idx, output logic [W-1:0] val);
        int best;
        best = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(sc[i]) > $signed(sc[best])) best = i;
        end
        idx = best;
        val = sc[best];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one scan, optionally scrambles inputs / re-pulses start mid-scan,
    // and checks latency, busy length, result and a single done pulse.
    task automatic run_scan(input string tag, input bit disturb);
        int exp_idx, lat, busy_cnt, extra;
        logic [W-1:0] exp_val;
        model(exp_idx, exp_val);
        IN_SCORES = pack_scores();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 4*N) begin
            if (busy) busy_cnt++;
            if (disturb) begin
                IN_SCORES = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                start = (lat == 3);
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, N - 1);
        check({tag, "_busy_cycles"}, busy_cnt, N - 1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_class"}, CLASS, exp_idx);
        check({tag, "_max"}, MAX_SCORE, exp_val);
        extra = 0;
        for (int c = 0; c < N + 2; c++) begin
            tick();
            if (done) extra++;
        end
        check({tag, "_extra_done"}, extra, 0);
        check({tag, "_class_hold"}, CLASS, exp_idx);
    endtask

    initial begin
        int e_idx, e_idx2, lat, gap, dcnt;
        logic [W-1:0] e_val, e_val2;

        rst = 1'b1;
        start = 1'b0;
        IN_SCORES = '0;
        repeat (3) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_class", CLASS, 0);
        check("reset_max", MAX_SCORE, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) sc[i] = W'(32'h0040000 * i);
        run_scan("ramp", 1'b0);
        check("ramp_max_const", MAX_SCORE, 26'h0240000);

        for (int i = 0; i < N; i++) sc[i] = '0;
        sc[3] = 26'h0080000;
        sc[7] = 26'h0080000;
        run_scan("tie", 1'b0);

        for (int i = 0; i < N; i++) sc[i] = 26'h3F80000;
        sc[5] = 26'h3FC0000;
        run_scan("neg", 1'b0);

        for (int i = 0; i < N; i++) sc[i] = W'($urandom);
        run_scan("disturb", 1'b1);

        // Abort a scan with reset 4 cycles after start.
        for (int i = 0; i < N; i++) sc[i] = W'(i + 1);
        IN_SCORES = pack_scores();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_class", CLASS, 0);
        check("abort_max", MAX_SCORE, 0);
        dcnt = 0;
        for (int c = 0; c < 2*N; c++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        run_scan("after_abort", 1'b0);

        // Back-to-back: start held across the done cycle.
        for (int i = 0; i < N; i++) sc[i] = W'($urandom);
        model(e_idx, e_val);
        IN_SCORES = pack_scores();
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) sc[i] = W'($urandom);
        model(e_idx2, e_val2);
        IN_SCORES = pack_scores();
        lat = 0;
        while (!done && lat < 4*N) begin
            tick();
            lat++;
        end
        check("b2b_lat1", lat, N - 1);
        check("b2b_class1", CLASS, e_idx);
        check("b2b_max1", MAX_SCORE, e_val);
        gap = 0;
        tick();
        gap++;
        start = 1'b0;
        while (!done && gap < 4*N) begin
            tick();
            gap++;
        end
        check("b2b_gap", gap, N);
        check("b2b_class2", CLASS, e_idx2);
        check("b2b_max2", MAX_SCORE, e_val2);
        repeat (2) tick();

        // Randomized sets; narrow value pools every other run to force ties.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) sc[i] = W'($urandom);
                else            sc[i] = W'($signed($urandom_range(0, 6)) - 3) <<< 18;
            end
            run_scan($sformatf("rand%0d", r), r % 4 == 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
